// File: rtl/rdpb18_pkg.sv
// rtl/rdpb18_pkg.sv - shared constants and helpers for the rdpb18 FIFO controller
// Purpose: active-low macro strobe levels, a constant clog2 and default
//          geometry for the 128x16 rdpb18 dual-port macro.
// Ports:   none (package).
package rdpb18_pkg;

    localparam logic SRAM_EN  = 1'b0;
    localparam logic SRAM_DIS = 1'b1;

    // rdpb18_128x16_g1 geometry
    localparam int DEF_DWIDTH = 16;
    localparam int DEF_AWIDTH = 7;

    // Bits needed to hold values 0..value-1; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rdpb18_fifo_ctrl_skid2.sv
// rtl/rdpb18_fifo_ctrl_skid2.sv - two-entry output buffer behind the SRAM read port
// Purpose: holds up to two words read from the macro so a full-rate stream
//          survives the one-cycle read latency.
// Ports:   clk, rst (sync, active-high); push/push_data write the tail;
//          pop removes the head; cnt = occupancy 0..2; head_data = head word.
module fifo_skid2
    import rdpb18_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [DWIDTH-1:0] head_data
);

    logic [DWIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_pop, do_push;

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != 2'd0);
        // A push into a full buffer is only legal when the head leaves.
        do_push = push && ((cnt_q != 2'd2) || do_pop);
        case (cnt_q)
            2'd0: begin
                if (do_push) begin
                    e0_d  = push_data;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    e0_d = push_data;
                end else if (do_push) begin
                    e1_d  = push_data;
                    cnt_d = 2'd2;
                end else if (do_pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                if (do_pop) begin
                    e0_d = e1_q;
                    if (do_push) begin
                        e1_d = push_data;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign head_data = e0_q;

endmodule

// File: rtl/rdpb18_fifo_ctrl.sv
// rtl/rdpb18_fifo_ctrl.sv - stream FIFO controller driving one rdpb18 dual-port SRAM macro
// Purpose: port A writes accepted input words, port B reads them back into a
//          two-entry output buffer that hides the macro read latency.
// Ports:   clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
//          out_valid/out_ready/out_data downstream; count = words held;
//          sram_* = macro address, data and active-low strobes.
module rdpb18_fifo_ctrl
    import rdpb18_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int AWIDTH = DEF_AWIDTH,
    parameter int DEPTH  = 2 ** AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH+1:0] count,
    output logic [AWIDTH-1:0] sram_aa,
    output logic              sram_csba,
    output logic              sram_weba,
    output logic              sram_reba,
    output logic              sram_oeba,
    output logic [DWIDTH-1:0] sram_ia,
    output logic [AWIDTH-1:0] sram_ab,
    output logic              sram_csbb,
    output logic              sram_webb,
    output logic              sram_rebb,
    output logic              sram_oebb,
    input  logic [DWIDTH-1:0] sram_ob
);

    localparam int               CNT_W    = clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(DEPTH);

    logic [AWIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [1:0]        ob_cnt;
    logic [2:0]        ob_occ;
    logic              wr_en, rd_issue, pop, push;

    always_comb begin
        out_valid = (ob_cnt != 2'd0);
        in_ready  = !rst && (mem_cnt_q != MEM_FULL);
        wr_en     = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // Buffer slots already spoken for after this cycle's pop; a new read
        // is only issued when its word is guaranteed a slot on arrival.
        ob_occ    = {1'b0, ob_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop};
        // mem_cnt excludes this cycle's write, so a word is never read in
        // the cycle it is written.
        rd_issue  = !rst && (mem_cnt_q != '0) && (ob_occ < 3'd2);
        // An in-flight read is dropped when reset arrives.
        push      = rd_inflight_q && !rst;

        wptr_d        = wr_en ? wptr_q + 1'b1 : wptr_q;
        rptr_d        = rd_issue ? rptr_q + 1'b1 : rptr_q;
        rd_inflight_d = rd_issue;
        mem_cnt_d     = mem_cnt_q;
        if (wr_en && !rd_issue) begin
            mem_cnt_d = mem_cnt_q + 1'b1;
        end else if (!wr_en && rd_issue) begin
            mem_cnt_d = mem_cnt_q - 1'b1;
        end

        sram_aa   = rst ? '0 : wptr_q;
        sram_ia   = in_data;
        sram_csba = wr_en ? SRAM_EN : SRAM_DIS;
        sram_weba = wr_en ? SRAM_EN : SRAM_DIS;
        sram_reba = SRAM_DIS;
        sram_oeba = SRAM_DIS;

        sram_ab   = rst ? '0 : rptr_q;
        sram_csbb = rd_issue ? SRAM_EN : SRAM_DIS;
        sram_rebb = rd_issue ? SRAM_EN : SRAM_DIS;
        sram_webb = SRAM_DIS;
        sram_oebb = rst ? SRAM_DIS : SRAM_EN;

        count = (AWIDTH+2)'(mem_cnt_q) + (AWIDTH+2)'(rd_inflight_q) + (AWIDTH+2)'(ob_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            mem_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            mem_cnt_q     <= mem_cnt_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    fifo_skid2 #(
        .DWIDTH(DWIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(sram_ob),
        .pop      (pop),
        .cnt      (ob_cnt),
        .head_data(out_data)
    );

endmodule

// File: tb/tb_rdpb18_fifo_ctrl.sv
// tb/tb_rdpb18_fifo_ctrl.sv - self-checking bench for rdpb18_fifo_ctrl
module tb_rdpb18_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data, sram_ia, sram_ob;
    logic [AW+1:0] count;
    logic [AW-1:0] sram_aa, sram_ab;
    logic          sram_csba, sram_weba, sram_reba, sram_oeba;
    logic          sram_csbb, sram_webb, sram_rebb, sram_oebb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    rdpb18_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .sram_aa(sram_aa), .sram_csba(sram_csba), .sram_weba(sram_weba),
        .sram_reba(sram_reba), .sram_oeba(sram_oeba), .sram_ia(sram_ia),
        .sram_ab(sram_ab), .sram_csbb(sram_csbb), .sram_webb(sram_webb),
        .sram_rebb(sram_rebb), .sram_oebb(sram_oebb), .sram_ob(sram_ob)
    );

    always #5 clk = ~clk;

    // Behavioural macro: synchronous write on A, one-cycle read latency on B.
    always @(posedge clk) begin
        if (sram_csba == 1'b0 && sram_weba == 1'b0) mem[sram_aa] <= sram_ia;
        if (sram_csbb == 1'b0 && sram_rebb == 1'b0) sram_ob <= mem[sram_ab];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1; in_valid = 1'b1; in_data = 16'hA5A5; out_ready = 1'b1;
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
            n_checks++; if ({sram_csba, sram_weba, sram_reba, sram_oeba, sram_csbb, sram_webb, sram_rebb, sram_oebb} !== 8'hFF) begin
                n_fail++; $display("FAIL reset_strobes: got %b want 11111111", {sram_csba, sram_weba, sram_reba, sram_oeba, sram_csbb, sram_webb, sram_rebb, sram_oebb}); end
            n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
            n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out: got valid %b data %h want 0/0000", out_valid, out_data); end
            n_checks++; if (sram_aa !== 7'd0 || sram_ab !== 7'd0) begin n_fail++; $display("FAIL reset_addr: got aa %0d ab %0d want 0/0", sram_aa, sram_ab); end
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_order();
        int sent = 0, got = 0, first = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 5); in_data = 16'(sent + 1); out_ready = 1'b1;
            #1;
            if (out_valid) begin
                if (first < 0) first = c;
                n_checks++; if (out_data !== 16'(got + 1)) begin n_fail++; $display("FAIL order_data: got %h want %h", out_data, 16'(got + 1)); end
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        n_checks++; if (first !== 3) begin n_fail++; $display("FAIL order_latency: got %0d want 3", first); end
        n_checks++; if (got !== 5) begin n_fail++; $display("FAIL order_words: got %0d want 5", got); end
        n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL order_count: got %0d want 0", count); end
    endtask

    task automatic test_full();
        int acc = 0, got = 0, csba_bad = 0;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 150; c++) begin
            in_data = 16'(acc);
            #1;
            if (in_ready) acc++;
            else if (sram_csba !== 1'b1) csba_bad++;
            tick();
        end
        n_checks++; if (acc !== 130) begin n_fail++; $display("FAIL full_accepted: got %0d want 130", acc); end
        n_checks++; if (count !== 9'd130) begin n_fail++; $display("FAIL full_count: got %0d want 130", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (csba_bad !== 0) begin n_fail++; $display("FAIL full_csba: got %0d writes while full want 0", csba_bad); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (out_valid) begin
                n_checks++; if (out_data !== 16'(got)) begin n_fail++; $display("FAIL full_drain_data: got %h want %h", out_data, 16'(got)); end
                got++;
            end
            tick();
        end
        n_checks++; if (got !== 130) begin n_fail++; $display("FAIL full_drain_words: got %0d want 130", got); end
        n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL full_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, bubbles = 0, bad_cnt = 0, data_err = 0;
        for (int c = 0; c < 1010; c++) begin
            in_valid = (sent < 1000); in_data = 16'(sent); out_ready = 1'b1;
            #1;
            if (c >= 3 && c < 1003 && !out_valid) bubbles++;
            if (c >= 3 && c < 1000 && count !== 9'd3) bad_cnt++;
            if (out_valid) begin
                if (out_data !== 16'(got)) data_err++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        n_checks++; if (sent !== 1000) begin n_fail++; $display("FAIL stream_accepted: got %0d want 1000", sent); end
        n_checks++; if (got !== 1000) begin n_fail++; $display("FAIL stream_words: got %0d want 1000", got); end
        n_checks++; if (bubbles !== 0) begin n_fail++; $display("FAIL stream_bubbles: got %0d want 0", bubbles); end
        n_checks++; if (bad_cnt !== 0) begin n_fail++; $display("FAIL stream_count: got %0d cycles off 3 want 0", bad_cnt); end
        n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL stream_data: got %0d bad words want 0", data_err); end
    endtask

    task automatic test_wrap_backpressure();
        logic [DW-1:0] sb[$];
        int sent = 0, got = 0, model_mem = 0, prev_aa = -1, prev_ab = -1;
        int data_err = 0, full_wr = 0, rdy_err = 0, saw_full = 0;
        bit wrap_a = 0, wrap_b = 0, wr, rd;
        for (int c = 0; c < 6000; c++) begin
            if (sent == 600 && got == 600) break;
            in_valid  = (sent < 600) && ($urandom_range(0, 9) < 8);
            out_ready = (sent < 300) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            #1;
            wr = (sram_csba == 1'b0 && sram_weba == 1'b0);
            rd = (sram_csbb == 1'b0 && sram_rebb == 1'b0);
            if (model_mem == DEPTH) saw_full++;
            if (wr) begin
                if (model_mem == DEPTH) full_wr++;
                if (prev_aa == 127 && sram_aa == 7'd0) wrap_a = 1;
                prev_aa = int'(sram_aa);
            end
            if (rd) begin
                if (prev_ab == 127 && sram_ab == 7'd0) wrap_b = 1;
                prev_ab = int'(sram_ab);
            end
            if (in_ready !== (model_mem != DEPTH)) rdy_err++;
            if (in_valid && in_ready) begin sb.push_back(in_data); sent++; end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) data_err++;
                else begin
                    if (out_data !== sb[0]) data_err++;
                    void'(sb.pop_front());
                end
                got++;
            end
            model_mem = model_mem + int'(wr) - int'(rd);
            tick();
        end
        out_ready = 1'b0; in_valid = 1'b0;
        n_checks++; if (got !== 600) begin n_fail++; $display("FAIL wrap_words: got %0d want 600", got); end
        n_checks++; if (data_err !== 0) begin n_fail++; $display("FAIL wrap_data: got %0d bad words want 0", data_err); end
        n_checks++; if (full_wr !== 0) begin n_fail++; $display("FAIL wrap_write_full: got %0d writes while full want 0", full_wr); end
        n_checks++; if (rdy_err !== 0) begin n_fail++; $display("FAIL wrap_in_ready: got %0d wrong cycles want 0", rdy_err); end
        n_checks++; if (saw_full == 0) begin n_fail++; $display("FAIL wrap_reached_full: got %0d full cycles want >0", saw_full); end
        n_checks++; if (wrap_a !== 1'b1 || wrap_b !== 1'b1) begin n_fail++; $display("FAIL wrap_addr: got aa %b ab %b want 1/1", wrap_a, wrap_b); end
    endtask

    task automatic test_mid_reset();
        int first = -1;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_data = 16'(c + 16'h100);
            #1;
            tick();
        end
        // Pop one and write one: a read is issued so one is in flight next cycle.
        in_data = 16'h0F0F; out_ready = 1'b1;
        #1;
        n_checks++; if (sram_csbb !== 1'b0) begin n_fail++; $display("FAIL midrst_issue: got csbb %b want 0", sram_csbb); end
        tick();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (count !== 9'd40) begin n_fail++; $display("FAIL midrst_pre_count: got %0d want 40", count); end
        n_checks++; if (sram_oebb !== 1'b1 || sram_csbb !== 1'b1) begin n_fail++; $display("FAIL midrst_strobes: got oebb %b csbb %b want 1/1", sram_oebb, sram_csbb); end
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0); in_data = 16'hBEEF; out_ready = 1'b1;
            #1;
            if (out_valid && first < 0) begin
                first = c;
                n_checks++; if (out_data !== 16'hBEEF) begin n_fail++; $display("FAIL midrst_first_word: got %h want beef", out_data); end
            end
            tick();
        end
        n_checks++; if (first !== 3) begin n_fail++; $display("FAIL midrst_latency: got %0d want 3", first); end
        n_checks++; if (count !== 9'd0) begin n_fail++; $display("FAIL midrst_final_count: got %0d want 0", count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick();
        test_reset();
        test_order();
        test_full();
        test_back_to_back();
        test_wrap_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
